// File: rtl/gbp_pkt_parser_pkg.sv
// Shared constants and types for the Game Boy printer link-layer parser.
// Holds the magic and ID bytes, command codes, status bit positions and the FSM state enum.
package gbp_pkg;

  localparam logic [7:0] MAGIC_1    = 8'h88;
  localparam logic [7:0] MAGIC_2    = 8'h33;
  localparam logic [7:0] DEVICE_ID  = 8'h81;

  localparam logic [7:0] CMD_INIT   = 8'h01;
  localparam logic [7:0] CMD_PRINT  = 8'h02;
  localparam logic [7:0] CMD_DATA   = 8'h04;
  localparam logic [7:0] CMD_STATUS = 8'h0F;

  localparam int SB_CHK_ERR = 0;
  localparam int SB_BUSY    = 1;
  localparam int SB_UNPROC  = 3;
  localparam int SB_PKT_ERR = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MAGIC2,
    ST_CMD,
    ST_COMP,
    ST_LENL,
    ST_LENH,
    ST_DATA,
    ST_CHKL,
    ST_CHKH,
    ST_ACK,
    ST_STAT
  } state_e;

endpackage

// File: rtl/gbp_pkt_parser_if.sv
// Bundles the SPI byte link, payload stream and packet/status reporting of the parser.
// The master modport is the parser itself; the slave modport is its surroundings.
interface gbp_pkt_parser_if #(parameter int IDX_W = 10);
  logic [7:0]       rx_dout;
  logic             rx_en;
  logic             print_busy;
  logic [7:0]       tx_din;
  logic [7:0]       data_out;
  logic             data_en;
  logic [IDX_W-1:0] data_idx;
  logic [7:0]       pkt_cmd;
  logic [15:0]      pkt_len;
  logic             pkt_done;
  logic [7:0]       status;

  modport master (
    input  rx_dout, rx_en, print_busy,
    output tx_din, data_out, data_en, data_idx, pkt_cmd, pkt_len, pkt_done, status
  );

  modport slave (
    output rx_dout, rx_en, print_busy,
    input  tx_din, data_out, data_en, data_idx, pkt_cmd, pkt_len, pkt_done, status
  );
endinterface

// File: rtl/gbp_pkt_parser_timeout.sv
// Saturating inter-byte idle counter; strobes timeout_o in the cycle it reaches TIMEOUT_CYC.
// A received byte clears the counter and suppresses the strobe in the same cycle.
module gbp_timeout #(
  parameter int TIMEOUT_CYC = 7373
) (
  input  logic clk,
  input  logic srst,
  input  logic rx_en_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rx_en_i)
      cnt_d = '0;
    else if (cnt_q != LIMIT)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign timeout_o = !rx_en_i && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/gbp_pkt_parser.sv
// Game Boy printer packet parser: frames bytes from spi_slv, streams payload to RAM,
// checks the 16-bit additive checksum and drives the device-ID/status reply bytes.
module gbp_pkt_parser
  import gbp_pkg::*;
#(
  parameter int MAX_LEN     = 640,
  parameter int TIMEOUT_CYC = 7373,
  parameter int IDX_W       = 10
) (
  input logic            clk,
  input logic            srst,
  gbp_pkt_parser_if.master pif
);

  state_e           state_q, state_d;
  logic [15:0]      csum_q, csum_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      len_q, len_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       lenl_q, lenl_d;
  logic [7:0]       chkl_q, chkl_d;
  logic             len_err_q, len_err_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       dout_q, dout_d;
  logic             den_q, den_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       pcmd_q, pcmd_d;
  logic [15:0]      plen_q, plen_d;
  logic             pdone_q, pdone_d;
  logic [7:0]       stat_q, stat_d;
  logic             timeout;
  logic             chk_err;

  gbp_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk       (clk),
    .srst      (srst),
    .rx_en_i   (pif.rx_en),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d   = state_q;
    csum_d    = csum_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    cmd_d     = cmd_q;
    lenl_d    = lenl_q;
    chkl_d    = chkl_q;
    len_err_d = len_err_q;
    tx_d      = tx_q;
    dout_d    = dout_q;
    den_d     = 1'b0;
    idx_d     = idx_q;
    pcmd_d    = pcmd_q;
    plen_d    = plen_q;
    pdone_d   = 1'b0;
    stat_d    = stat_q;
    stat_d[SB_BUSY] = pif.print_busy;
    chk_err   = ({pif.rx_dout, chkl_q} != csum_q) || len_err_q;

    if (pif.rx_en) begin
      tx_d = 8'h00;
      unique case (state_q)
        ST_IDLE:   if (pif.rx_dout == MAGIC_1) state_d = ST_MAGIC2;
        ST_MAGIC2: begin
          if (pif.rx_dout == MAGIC_2) begin
            state_d = ST_CMD;
            csum_d  = '0;
          end else if (pif.rx_dout != MAGIC_1) begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          cmd_d   = pif.rx_dout;
          csum_d  = csum_q + {8'h00, pif.rx_dout};
          state_d = ST_COMP;
        end
        ST_COMP: begin
          csum_d  = csum_q + {8'h00, pif.rx_dout};
          state_d = ST_LENL;
        end
        ST_LENL: begin
          lenl_d  = pif.rx_dout;
          csum_d  = csum_q + {8'h00, pif.rx_dout};
          state_d = ST_LENH;
        end
        ST_LENH: begin
          len_d     = {pif.rx_dout, lenl_q};
          len_err_d = {pif.rx_dout, lenl_q} > 16'(MAX_LEN);
          csum_d    = csum_q + {8'h00, pif.rx_dout};
          cnt_d     = '0;
          state_d   = ({pif.rx_dout, lenl_q} == 16'd0) ? ST_CHKL : ST_DATA;
        end
        ST_DATA: begin
          dout_d = pif.rx_dout;
          idx_d  = cnt_q[IDX_W-1:0];
          den_d  = !len_err_q;
          csum_d = csum_q + {8'h00, pif.rx_dout};
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) state_d = ST_CHKL;
        end
        ST_CHKL: begin
          chkl_d  = pif.rx_dout;
          state_d = ST_CHKH;
        end
        ST_CHKH: begin
          stat_d[SB_CHK_ERR] = chk_err;
          if (len_err_q) stat_d[SB_PKT_ERR] = 1'b1;
          if (!chk_err) begin
            pcmd_d  = cmd_q;
            plen_d  = len_q;
            pdone_d = 1'b1;
            if (cmd_q == CMD_INIT) begin
              stat_d[SB_UNPROC]  = 1'b0;
              stat_d[SB_PKT_ERR] = 1'b0;
            end else if (cmd_q == CMD_PRINT) begin
              stat_d[SB_UNPROC] = 1'b0;
            end else if (cmd_q == CMD_DATA && len_q != 16'd0) begin
              stat_d[SB_UNPROC] = 1'b1;
            end
          end
          tx_d    = DEVICE_ID;
          state_d = ST_ACK;
        end
        ST_ACK: begin
          tx_d    = stat_d;
          state_d = ST_STAT;
        end
        ST_STAT:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else if (timeout && state_q != ST_IDLE) begin
      // Host went silent mid-packet: drop it and resync on the next magic.
      state_d = ST_IDLE;
      tx_d    = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      csum_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      cmd_q     <= '0;
      lenl_q    <= '0;
      chkl_q    <= '0;
      len_err_q <= 1'b0;
      tx_q      <= '0;
      dout_q    <= '0;
      den_q     <= 1'b0;
      idx_q     <= '0;
      pcmd_q    <= '0;
      plen_q    <= '0;
      pdone_q   <= 1'b0;
      stat_q    <= '0;
    end else begin
      state_q   <= state_d;
      csum_q    <= csum_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      cmd_q     <= cmd_d;
      lenl_q    <= lenl_d;
      chkl_q    <= chkl_d;
      len_err_q <= len_err_d;
      tx_q      <= tx_d;
      dout_q    <= dout_d;
      den_q     <= den_d;
      idx_q     <= idx_d;
      pcmd_q    <= pcmd_d;
      plen_q    <= plen_d;
      pdone_q   <= pdone_d;
      stat_q    <= stat_d;
    end
  end

  assign pif.tx_din   = tx_q;
  assign pif.data_out = dout_q;
  assign pif.data_en  = den_q;
  assign pif.data_idx = idx_q;
  assign pif.pkt_cmd  = pcmd_q;
  assign pif.pkt_len  = plen_q;
  assign pif.pkt_done = pdone_q;
  assign pif.status   = stat_q;

endmodule

// File: tb/tb_gbp_pkt_parser.sv
// Scoreboard bench for gbp_pkt_parser: stimulus pushes expected reply bytes, payload
// strobes and packet completions into queues; a negedge monitor pops and compares them.
module tb_gbp_pkt_parser;

  localparam int TIMEOUT_CYC = 7373;
  localparam int IDX_W       = 10;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  gbp_pkt_parser_if #(.IDX_W(IDX_W)) pif ();

  gbp_pkt_parser #(
    .MAX_LEN     (640),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .IDX_W       (IDX_W)
  ) dut (
    .clk  (clk),
    .srst (srst),
    .pif  (pif)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  expTxQ[$];
  logic [17:0] expDataQ[$];
  logic [23:0] expDoneQ[$];
  logic [7:0]  payload[$];
  logic        rxSeen = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: unexpected output 0x%0h with nothing expected", name, act);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tx_din"},   pif.tx_din,   32'h0);
    checkOutput({tag, "_data_out"}, pif.data_out, 32'h0);
    checkOutput({tag, "_data_en"},  pif.data_en,  32'h0);
    checkOutput({tag, "_data_idx"}, pif.data_idx, 32'h0);
    checkOutput({tag, "_pkt_cmd"},  pif.pkt_cmd,  32'h0);
    checkOutput({tag, "_pkt_len"},  pif.pkt_len,  32'h0);
    checkOutput({tag, "_pkt_done"}, pif.pkt_done, 32'h0);
    checkOutput({tag, "_status"},   pif.status,   32'h0);
  endtask

  // One received byte, with the reply byte tx_din must hold after it.
  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] expTx);
    expTxQ.push_back(expTx);
    @(negedge clk);
    pif.rx_dout = b;
    pif.rx_en   = 1'b1;
    @(negedge clk);
    pif.rx_en   = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Full frame: magic, cmd, comp 0, len, payload queue, checksum, two reply bytes.
  task automatic sendPacket(input logic [7:0] cmd, input logic [15:0] len, input logic [15:0] chk,
                            input logic [7:0] replySt, input bit good, input bit dataOk);
    applyStimulus(8'h88, 8'h00);
    applyStimulus(8'h33, 8'h00);
    applyStimulus(cmd, 8'h00);
    applyStimulus(8'h00, 8'h00);
    applyStimulus(len[7:0], 8'h00);
    applyStimulus(len[15:8], 8'h00);
    for (int i = 0; i < payload.size(); i++) begin
      if (dataOk) expDataQ.push_back({10'(i), payload[i]});
      applyStimulus(payload[i], 8'h00);
    end
    applyStimulus(chk[7:0], 8'h00);
    if (good) expDoneQ.push_back({cmd, len});
    applyStimulus(chk[15:8], 8'h81);
    applyStimulus(8'h00, replySt);
    applyStimulus(8'h00, 8'h00);
  endtask

  always @(posedge clk) rxSeen <= pif.rx_en;

  always @(negedge clk) begin
    if (!srst) begin
      if (rxSeen) begin
        if (expTxQ.size() == 0) reportUnexpected("tx_din", 32'(pif.tx_din));
        else checkOutput("tx_din", pif.tx_din, expTxQ.pop_front());
      end
      if (pif.data_en) begin
        if (expDataQ.size() == 0) reportUnexpected("data_en", {pif.data_idx, pif.data_out});
        else checkOutput("data_idx_byte", {pif.data_idx, pif.data_out}, expDataQ.pop_front());
      end
      if (pif.pkt_done) begin
        if (expDoneQ.size() == 0) reportUnexpected("pkt_done", {pif.pkt_cmd, pif.pkt_len});
        else checkOutput("pkt_cmd_len", {pif.pkt_cmd, pif.pkt_len}, expDoneQ.pop_front());
      end
    end
  end

  initial begin
    pif.rx_en      = 1'b0;
    pif.rx_dout    = 8'h00;
    pif.print_busy = 1'b0;
    srst           = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    srst = 1'b0;
    @(negedge clk);

    $display("[TB] init packet");
    payload.delete();
    sendPacket(8'h01, 16'h0000, 16'h0001, 8'h00, 1'b1, 1'b1);
    checkOutput("init_pkt_cmd", pif.pkt_cmd, 32'h01);
    checkOutput("init_status", pif.status, 32'h00);

    $display("[TB] good data packet");
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    sendPacket(8'h04, 16'h0004, 16'h00B2, 8'h08, 1'b1, 1'b1);
    checkOutput("data_pkt_len", pif.pkt_len, 32'h0004);
    checkOutput("data_status", pif.status, 32'h08);

    payload.delete();
    sendPacket(8'h01, 16'h0000, 16'h0001, 8'h00, 1'b1, 1'b1);
    checkOutput("reinit_status", pif.status, 32'h00);

    $display("[TB] bad checksum packet");
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    sendPacket(8'h04, 16'h0004, 16'h00B3, 8'h01, 1'b0, 1'b1);
    checkOutput("badchk_pkt_cmd", pif.pkt_cmd, 32'h01);
    checkOutput("badchk_status", pif.status, 32'h01);

    $display("[TB] oversize packet");
    payload.delete();
    for (int i = 0; i < 641; i++) payload.push_back(8'(i));
    sendPacket(8'h04, 16'h0281, 16'h0000, 8'h11, 1'b0, 1'b0);
    checkOutput("oversize_status", pif.status, 32'h11);
    checkOutput("oversize_pkt_len", pif.pkt_len, 32'h0000);

    $display("[TB] timeout after LENL");
    applyStimulus(8'h88, 8'h00);
    applyStimulus(8'h33, 8'h00);
    applyStimulus(8'h01, 8'h00);
    applyStimulus(8'h00, 8'h00);
    applyStimulus(8'h00, 8'h00);
    repeat (TIMEOUT_CYC + 2) @(negedge clk);
    checkOutput("timeout_status_kept", pif.status, 32'h11);
    payload.delete();
    sendPacket(8'h01, 16'h0000, 16'h0001, 8'h00, 1'b1, 1'b1);
    checkOutput("post_timeout_status", pif.status, 32'h00);

    $display("[TB] repeated magic");
    applyStimulus(8'h88, 8'h00);
    sendPacket(8'h01, 16'h0000, 16'h0001, 8'h00, 1'b1, 1'b1);

    $display("[TB] reset during DATA");
    applyStimulus(8'h88, 8'h00);
    applyStimulus(8'h33, 8'h00);
    applyStimulus(8'h04, 8'h00);
    applyStimulus(8'h00, 8'h00);
    applyStimulus(8'h04, 8'h00);
    applyStimulus(8'h00, 8'h00);
    expDataQ.push_back({10'd0, 8'h11});
    applyStimulus(8'h11, 8'h00);
    expDataQ.push_back({10'd1, 8'h22});
    applyStimulus(8'h22, 8'h00);
    srst = 1'b1;
    @(negedge clk);
    checkResetOutputs("midreset");
    srst = 1'b0;
    @(negedge clk);

    $display("[TB] data packet with 0x88 payload after reset");
    payload = '{8'h88, 8'h33};
    sendPacket(8'h04, 16'h0002, 16'h00C1, 8'h08, 1'b1, 1'b1);
    checkOutput("post_reset_pkt_len", pif.pkt_len, 32'h0002);

    pif.print_busy = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("busy_status", pif.status, 32'h0A);
    pif.print_busy = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("tx_q_drained",   expTxQ.size(),   32'd0);
    checkOutput("data_q_drained", expDataQ.size(), 32'd0);
    checkOutput("done_q_drained", expDoneQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
